load_seq_ctrl: RTL and testbench

Multi-cycle load sequencer between the pipeline control unit and the 64-bit data memory port. It accepts one RV64I load per request, aligns and issues a doubleword read, waits for the memory response, then extracts and sign/zero-extends the addressed lane. It holds the pipeline stalled for the whole access and delivers one registered writeback word.

---
 rtl/load_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_load_seq_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/load_seq_ctrl.sv
// RV64I load sequencer: issues an aligned doubleword read, waits for the response, then extracts and extends the addressed lane.
// Optional macro LOAD_MISALIGN_TRAP_EN: a misaligned access raises err instead of being truncated to its natural alignment.
module load_seq_ctrl #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAIL} state_t;

  state_t          state;
  logic [2:0]      f3_q;
  logic [2:0]      off_q;
  logic [7:0]      cnt;
  logic [2:0]      eff_off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;
  logic            misaligned;

  // Offset bits below the access size are dropped, so no lane crosses the doubleword.
  always_comb begin
    eff_off = off_q;
    case (f3_q[1:0])
      2'b01:   eff_off = {off_q[2:1], 1'b0};
      2'b10:   eff_off = {off_q[2], 2'b00};
      2'b11:   eff_off = 3'b000;
      default: eff_off = off_q;
    endcase
  end

  assign shifted = mem_rdata >> {eff_off, 3'b000};

  always_comb begin
    ext = shifted;
    case (f3_q)
      3'b000:  ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      2'b11:   misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Combinational so the issuing cycle is already stalled.
  assign stall = (state == S_REQ) || (state == S_WAIT) || ((state == S_IDLE) && start);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      f3_q     <= 3'b000;
      off_q    <= 3'b000;
      cnt      <= 8'd0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      mem_req  <= 1'b0;
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_q     <= funct3;
            off_q    <= addr[2:0];
            mem_addr <= {addr[XLEN-1:3], 3'b000};
            if ((funct3 == 3'b111) || misaligned) begin
              state <= S_FAIL;
              err   <= 1'b1;
            end else begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            state <= S_WAIT;
            cnt   <= 8'd0;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_WAIT: begin
          // Response wins over a timeout landing in the same cycle.
          if (mem_rvalid) begin
            wb_data  <= ext;
            wb_valid <= 1'b1;
            state    <= S_DONE;
          end else if (cnt == 8'(TIMEOUT_CYCLES)) begin
            state <= S_FAIL;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAIL:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Self-checking bench for load_seq_ctrl: directed plan cases plus random loads against a cycle-count reference model.
module tb_load_seq_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_wb = 64'd0;

  load_seq_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .addr(addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result: size n bytes, offset rounded down to a multiple of n, then extended.
  function automatic logic [63:0] model_data(input logic [2:0] f3, input logic [63:0] a,
                                              input logic [63:0] rd);
    int n, o;
    logic [63:0] mask, field;
    n = 1 << f3[1:0];
    o = int'(a[2:0]);
    o = o - (o % n);
    mask = (n == 8) ? ~64'd0 : ((64'd1 << (8 * n)) - 64'd1);
    field = (rd >> (8 * o)) & mask;
    if (!f3[2] && n < 8 && field[8 * n - 1]) field = field | ~mask;
    return field;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [63:0] a);
`ifdef LOAD_MISALIGN_TRAP_EN
    int n;
    n = 1 << f3[1:0];
    return (int'(a[2:0]) % n) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // One load, cycle 0 = start cycle. gd = grant delay, rdly = WAIT cycles before rvalid.
  task automatic run_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd,
                          input int gd, input int rdly);
    bit legal, ok;
    int end_c;
    logic [63:0] exp_d;
    legal = (f3 != 3'b111) && !model_misaligned(f3, a);
    ok    = legal && (rdly <= TO);
    exp_d = model_data(f3, a, rd);
    if (!legal)  end_c = 1;
    else if (ok) end_c = 3 + gd + rdly;
    else         end_c = 2 + gd + TO + 1;
    for (int c = 0; c <= end_c; c++) begin
      @(posedge clk); #1;
      start      = (c == 0);
      funct3     = (c == 0) ? f3 : 3'($urandom_range(0, 7));
      addr       = (c == 0) ? a : {$urandom, $urandom};
      mem_gnt    = legal && (c == 1 + gd);
      mem_rvalid = legal && (c == 2 + gd + rdly);
      mem_rdata  = mem_rvalid ? rd : {$urandom, $urandom};
      #1;
      chk($sformatf("req c%0d f3=%0d", c, f3), 64'(mem_req), 64'(legal && c >= 1 && c <= 1 + gd));
      chk($sformatf("stall c%0d", c), 64'(stall), 64'(c < end_c));
      chk($sformatf("wb_valid c%0d", c), 64'(wb_valid), 64'(ok && c == end_c));
      chk($sformatf("err c%0d", c), 64'(err), 64'(!ok && c == end_c));
      if (legal && c == 1) chk("mem_addr", mem_addr, {a[63:3], 3'b000});
      if (c == end_c) begin
        if (ok) last_wb = exp_d;
        chk($sformatf("wb_data f3=%0d a=%h", f3, a), wb_data, last_wb);
      end
    end
    start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    $display("load f3=%0d addr=%h gd=%0d rdly=%0d -> %s data=%h", f3, a, gd, rdly,
             ok ? "wb" : "err", wb_data);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'b000; addr = 64'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst wb_valid", 64'(wb_valid), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst wb_data", wb_data, 64'd0);
    chk("rst mem_addr", mem_addr, 64'd0);
    @(posedge clk); #1; reset = 1'b0;

    run_load(3'b000, 64'h1003, 64'h00000000_80FF0000, 0, 0);
    chk("lb plan value", wb_data, 64'hFFFFFFFF_FFFFFF80);
    run_load(3'b110, 64'h2004, 64'hDEADBEEF_00000000, 0, 0);
    chk("lwu plan value", wb_data, 64'h00000000_DEADBEEF);
    run_load(3'b011, 64'h3000, 64'h01234567_89ABCDEF, 3, 2);
    run_load(3'b111, 64'h4000, 64'h0, 0, 0);
    run_load(3'b010, 64'h5008, 64'h0, 0, 100);

    // Reset while in WAIT, then a late response must be ignored.
    @(posedge clk); #1; start = 1'b1; funct3 = 3'b011; addr = 64'h40;
    @(posedge clk); #1; start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("midrst mem_req", 64'(mem_req), 64'd0);
    chk("midrst stall", 64'(stall), 64'd0);
    chk("midrst wb_valid", 64'(wb_valid), 64'd0);
    chk("midrst err", 64'(err), 64'd0);
    chk("midrst wb_data", wb_data, 64'd0);
    chk("midrst mem_addr", mem_addr, 64'd0);
    @(posedge clk); #1; mem_rvalid = 1'b0; #1;
    chk("late rvalid wb_valid", 64'(wb_valid), 64'd0);
    chk("late rvalid wb_data", wb_data, 64'd0);
    last_wb = 64'd0;
    $display("reset in WAIT -> outputs cleared");
    run_load(3'b001, 64'h10, 64'h12345678_9ABC8001, 0, 0);
    chk("lh after reset", wb_data, 64'hFFFFFFFF_FFFF8001);

    run_load(3'b001, 64'h11, 64'h00000000_00008001, 0, 0);
`ifndef LOAD_MISALIGN_TRAP_EN
    chk("lh misaligned truncated", wb_data, 64'hFFFFFFFF_FFFF8001);
`endif

    for (int i = 0; i < 30; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 9) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      run_load(f3, {$urandom, $urandom}, {$urandom, $urandom},
               int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
